// File: rtl/instr_fetch_if.sv
// Instruction-memory port for the fetch stage: one request/grant handshake
// and one read-response channel.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, keeps at most one instruction-memory read in
// flight, and holds one fetched instruction for decode until it is consumed.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic               stall_i,
  instr_fetch_if.master      imem_if,
  output logic [31:0]        instruction_o,
  output logic [31:0]        pc_o,
  output logic               inst_valid_o,
  output logic               misaligned_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        req_q, req_d;

  logic        redirect_s;
  logic [31:0] target_s;

  assign redirect_s = redirect_valid_i && (state_q != IDLE);
  assign target_s   = {redirect_pc_i[31:2], 2'b00};

  // Next-state, fetch address and held-instruction update; redirect wins over everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    mis_d      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // A grant in the redirect cycle means the old address already went out.
        if (redirect_s) begin
          state_d = imem_if.gnt ? DRAIN : REQ;
        end else if (imem_if.gnt) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (redirect_s) begin
          state_d = DRAIN;
        end else if (imem_if.rvalid) begin
          instr_d    = imem_if.rdata;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          state_d = REQ;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_s) begin
          state_d = DRAIN;
        end else if (imem_if.rvalid) begin
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_s) begin
      fetch_pc_d = target_s;
      mis_d      = (redirect_pc_i[1:0] != 2'b00);
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end else begin
      mis_d = 1'b0;
    end
  end

  assign req_d = (state_d == REQ);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      req_q      <= req_d;
    end
  end

  assign imem_if.req   = req_q;
  assign imem_if.addr  = fetch_pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign inst_valid_o  = valid_q;
  assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        inst_valid;
  logic        misaligned;

  instr_fetch_if imem ();

  instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .stall_i          (stall),
    .imem_if          (imem),
    .instruction_o    (instruction),
    .pc_o             (pc),
    .inst_valid_o     (inst_valid),
    .misaligned_o     (misaligned)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: one in-flight read (m_out/m_stale/m_out_addr), one held instruction
  // (m_valid/m_pc/m_instr) and the next fetch address m_next.
  bit          m_started, m_out, m_stale, m_valid, m_mis;
  logic [31:0] m_out_addr, m_pc, m_instr, m_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
    m_out_addr = RST_PC; m_pc = RST_PC; m_instr = NOP; m_next = RST_PC;
  endtask

  task automatic model_step();
    bit req_now;
    req_now = m_started && !m_valid && !m_out;
    if (!m_started) begin
      m_started = 1'b1;
      m_mis     = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (redirect_valid) begin
        m_next  = {redirect_pc[31:2], 2'b00};
        m_mis   = (redirect_pc[1:0] != 2'b00);
        m_valid = 1'b0;
        if (req_now && imem.gnt) begin
          m_out   = 1'b1;
          m_stale = 1'b1;
        end else if (m_out) begin
          m_stale = 1'b1;
        end
      end else if (req_now && imem.gnt) begin
        m_out      = 1'b1;
        m_stale    = 1'b0;
        m_out_addr = m_next;
      end else if (m_out && imem.rvalid) begin
        m_out = 1'b0;
        if (!m_stale) begin
          m_valid = 1'b1;
          m_pc    = m_out_addr;
          m_instr = imem.rdata;
          m_next  = m_out_addr + 32'd4;
        end
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk1("req", imem.req, m_started && !m_valid && !m_out);
    chk("addr", imem.addr, m_next);
    chk1("inst_valid", inst_valid, m_valid);
    chk("pc", pc, m_pc);
    chk("instruction", instruction, m_valid ? m_instr : NOP);
    chk1("misaligned", misaligned, m_mis);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem.gnt       = 1'b0;
    imem.rvalid    = 1'b0;
    imem.rdata     = 32'h0;
  endtask

  task automatic mem_auto();
    imem.gnt    = 1'b1;
    imem.rvalid = m_out;
    imem.rdata  = m_stale ? 32'hDEAD_BEEF : mem_word(m_out_addr);
  endtask

  initial begin
    logic [31:0] save_pc, save_instr;
    set_idle();
    redirect_pc = 32'h0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Reset and first fetch
    mem_auto(); cyc();
    chk1("t1_first_req", imem.req, 1'b1);
    chk("t1_first_addr", imem.addr, 32'h0);
    for (int k = 0; k < 10 && !inst_valid; k++) begin mem_auto(); cyc(); end
    chk1("t1_valid", inst_valid, 1'b1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_instr", instruction, 32'h0050_0093);

    // Stall hold
    save_pc = pc; save_instr = instruction;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_auto(); cyc();
      chk("t2_pc_stable", pc, save_pc);
      chk("t2_instr_stable", instruction, save_instr);
      chk1("t2_valid_stable", inst_valid, 1'b1);
      chk1("t2_no_req", imem.req, 1'b0);
    end
    stall = 1'b0;
    mem_auto(); cyc();
    chk1("t2_req_after", imem.req, 1'b1);
    chk("t2_addr_after", imem.addr, save_pc + 32'd4);

    // Redirect during WAIT
    for (int k = 0; k < 20 && !(m_out && m_out_addr == 32'h8); k++) begin mem_auto(); cyc(); end
    chk1("t3_in_wait", imem.req, 1'b0);
    chk("t3_wait_addr", imem.addr, 32'h8);
    set_idle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF; end
      cyc();
      chk1("t3_no_stale", instruction == 32'hDEAD_BEEF, 1'b0);
    end
    set_idle();
    chk1("t3_req", imem.req, 1'b1);
    chk("t3_addr", imem.addr, 32'h100);

    // Redirect coincident with gnt
    imem.gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    set_idle();
    chk1("t4_drain_noreq", imem.req, 1'b0);
    cyc();
    chk1("t4_drain_hold", imem.req, 1'b0);
    imem.rvalid = 1'b1; imem.rdata = mem_word(32'h100);
    cyc();
    set_idle();
    chk1("t4_discarded", inst_valid, 1'b0);
    chk1("t4_req", imem.req, 1'b1);
    chk("t4_addr", imem.addr, 32'h40);

    // Misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0106;
    cyc();
    set_idle();
    chk1("t5_mis_pulse", misaligned, 1'b1);
    chk("t5_addr", imem.addr, 32'h104);
    cyc();
    chk1("t5_mis_clear", misaligned, 1'b0);

    // Wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    set_idle();
    for (int k = 0; k < 10 && !inst_valid; k++) begin mem_auto(); cyc(); end
    chk1("t6_valid", inst_valid, 1'b1);
    chk("t6_pc", pc, 32'hFFFF_FFFC);
    mem_auto(); cyc();
    chk1("t6_req", imem.req, 1'b1);
    chk("t6_wrap_addr", imem.addr, 32'h0);

    // Asynchronous reset mid-WAIT, then a late response
    imem.gnt = 1'b1;
    cyc();
    set_idle();
    chk1("t7_in_wait", imem.req, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("t7_pc_reset", pc, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    cyc();
    chk1("t7_late_ignored", inst_valid, 1'b0);
    cyc();
    chk1("t7_late_ignored2", inst_valid, 1'b0);
    chk1("t7_req", imem.req, 1'b1);
    set_idle();

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 1) == 1) redirect_pc[1:0] = 2'b00;
      stall       = ($urandom_range(0, 2) == 0);
      imem.gnt    = ($urandom_range(0, 1) == 1);
      imem.rvalid = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      imem.rdata  = (m_out && !m_stale) ? mem_word(m_out_addr) : $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the RV32I core. It holds the program counter, fetches one instruction at a time over a request/grant/response memory port, and presents the `pc` and `instruction` pair to decode and the immediate generator. The generator's branch, jump and JALR targets come back through the redirect port. At most one memory transaction is outstanding, and a response made stale by a redirect is drained and discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset. Must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instruction` while nothing valid is held (`addi x0,x0,0`).

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: taken branch, JAL or JALR this cycle.
- `redirect_pc` in 32: new fetch target.
- `stall` in 1: downstream cannot accept the held instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to `fetch_pc`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instruction` out 32: held instruction.
- `pc` out 32: address of the held instruction.
- `inst_valid` out 1: `instruction` and `pc` are valid.
- `misaligned` out 1: one-cycle pulse, set when the accepted redirect target had `[1:0] != 0`.

## Operation
- States: `IDLE`, `REQ`, `WAIT`, `HOLD`, `DRAIN`. Internal register `fetch_pc` (32 bits).
- `IDLE`: entered only from reset. Unconditionally moves to `REQ` on the next cycle.
- `REQ`: `imem_req`=1.
  - `imem_gnt`=1 moves to `WAIT`.
- `WAIT`: waits for `imem_rvalid`.
  - On `imem_rvalid`: `instruction`←`imem_rdata`, `pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), `inst_valid`←1, move to `HOLD`.
- `HOLD`: outputs frozen while `stall`=1.
  - When `stall`=0, the instruction is consumed at that edge: `inst_valid`←0, `instruction`←`NOP_INSTR`, move to `REQ`.
- `DRAIN`: waits for the stale response.
  - On `imem_rvalid`: discard the data, move to `REQ`.
- Redirect takes priority over all other events, in every state except `IDLE`:
  - Always: `fetch_pc`←{`redirect_pc[31:2]`,2'b00}, `misaligned`←(`redirect_pc[1:0]`!=0), `inst_valid`←0, `instruction`←`NOP_INSTR`.
  - `REQ` without `gnt` in the same cycle: stay in `REQ`; the next request carries the new address.
  - `REQ` with `gnt` in the same cycle: the old-address request was issued, so move to `DRAIN`.
  - `WAIT`: move to `DRAIN`. This applies even if `imem_rvalid` arrives in the same cycle; that data is discarded and the drain completes on the next `rvalid`.
  - `HOLD`: move to `REQ`.
  - `DRAIN`: stay in `DRAIN`; only the latest target is kept.
- `imem_rvalid` outside `WAIT` and `DRAIN` is ignored.
- `imem_gnt` outside `REQ` is ignored.

## Timing
- Reset values:
  - state=`IDLE`, `fetch_pc`=`RESET_PC`, `pc`=`RESET_PC`, `instruction`=`NOP_INSTR`.
  - `inst_valid`=0, `misaligned`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
- Reset asserted mid-transaction: everything is abandoned immediately (asynchronous). A late response is ignored because the state is `IDLE` or `REQ`.
- `imem_req` and `imem_addr` are decoded from registered state only; there is no combinational path from any input.
- First `imem_req` appears in the 2nd rising-edge cycle after `rst` deasserts.
- Best-case latency: `gnt` in cycle n, `rvalid` in n+1, `inst_valid`=1 in n+2.
- Best-case throughput with `stall`=0: one instruction per 3 cycles.
- A redirect in cycle n gives `inst_valid`=0 at n+1. With no stale drain, `imem_addr` shows the target at n+1.
- `misaligned` is high for exactly one cycle, the cycle after the redirect edge.

## Test plan
- Reset and first fetch:
  - Stimulus: `RESET_PC`=0; memory always grants and responds with `rdata`=0x00500093 one cycle after `gnt`.
  - Required: first `imem_addr`=0; `inst_valid` with `pc`=0, `instruction`=0x00500093; next `imem_addr`=4.
- Stall hold:
  - Stimulus: hold `stall`=1 for 5 cycles while `inst_valid`=1.
  - Required: `pc`, `instruction` and `inst_valid` are stable and `imem_req`=0; after `stall` drops, the next request has `addr`=`pc`+4.
- Redirect during `WAIT`:
  - Stimulus: after `gnt` at addr 0x8, pulse redirect to 0x100; stale `rvalid` 3 cycles later with `rdata`=0xDEADBEEF.
  - Required: `inst_valid` never shows 0xDEADBEEF; next `imem_addr`=0x100.
- Redirect coincident with `gnt`:
  - Stimulus: in `REQ`, `gnt` and redirect to 0x40 in the same cycle.
  - Required: FSM enters `DRAIN`; the first response is discarded; next `imem_addr`=0x40.
- Misaligned target:
  - Stimulus: redirect to 0x0000_0106.
  - Required: `misaligned`=1 for one cycle; next `imem_addr`=0x104.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC and complete the fetch.
  - Required: next `imem_addr`=0.
  - Stimulus: assert `rst` mid-`WAIT`, then deliver a late `rvalid`.
  - Required: outputs return to reset values immediately; the late `rvalid` is ignored.
